// File: rtl/inst_encoder_loader.sv
// Assembles RV32I instruction words from symbolic requests and streams them
// sequentially into instruction memory, one word per two cycles at most.
module inst_encoder_loader #(
  parameter int                ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_type,
  input  logic [2:0]        req_funct3,
  input  logic              req_f7b5,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [12:0]       req_imm,
  input  logic              flush,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              err_reg, err_next;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              accept;
  logic [ADDR_W:0]   count_inc;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (req_type)
      3'd0: enc_word = {1'b0, req_f7b5, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, 7'b0110011};
      3'd1: enc_word = {req_imm[11:0], req_rs1, 3'b010, req_rd, 7'b0000011};
      3'd2: enc_word = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], 7'b0100011};
      3'd3: begin
        // Branch offsets are halfword-granular; an odd byte offset cannot be encoded.
        enc_word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b000,
                     req_imm[4:1], req_imm[11], 7'b1100011};
        enc_legal = ~req_imm[0];
      end
      3'd4: enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b0010011};
      default: enc_legal = 1'b0;
    endcase
  end

  assign req_ready = rst_n && (state_reg == ST_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign count_inc = count_reg + (ADDR_W+1)'(1);

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    count_next = count_reg;
    err_next   = err_reg;
    if (flush) begin
      state_next = ST_IDLE;
      addr_next  = BASE_ADDR;
      count_next = '0;
      err_next   = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (enc_legal) begin
              wdata_next = enc_word;
              state_next = ST_WRITE;
            end else begin
              err_next = 1'b1;
            end
          end
        end
        ST_WRITE: begin
          // Fullness tracks words written, so a nonzero base still yields full capacity.
          addr_next  = addr_reg + ADDR_W'(1);
          count_next = count_inc;
          state_next = (count_inc == CAPACITY) ? ST_FULL : ST_IDLE;
        end
        ST_FULL: state_next = ST_FULL;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      addr_reg  <= BASE_ADDR;
      wdata_reg <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  // A flush arriving during the write cycle cancels the strobe immediately.
  assign imem_we    = (state_reg == ST_WRITE) && !flush;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign word_count = count_reg;
  assign full       = (state_reg == ST_FULL);
  assign err        = err_reg;

endmodule
